count_datapath: RTL and testbench

COUNT_DATAPATH -- requirements
Module: count_datapath

---
 rtl/count_datapath_pkg.sv | 24 ++
 rtl/count_datapath_tick_prescaler.sv | 34 +++
 rtl/count_datapath.sv | 115 +++++++++++
 tb/tb_count_datapath.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/count_datapath_pkg.sv
// Shared constants and helpers for the BCD count datapath and its prescaler.
package count_datapath_pkg;

  localparam int BCD_W       = 8;
  localparam int NUM_STROBES = 6;

  localparam int S0_IDX = 0;
  localparam int S1_IDX = 1;
  localparam int S2_IDX = 2;
  localparam int S3_IDX = 3;
  localparam int S4_IDX = 4;
  localparam int S5_IDX = 5;

  localparam logic [BCD_W-1:0] LIMIT_DEFAULT = 8'h59;

  typedef logic [BCD_W-1:0]       bcd_t;
  typedef logic [NUM_STROBES-1:0] strobe_vec_t;

  // True when two or more strobes are high at once (clears the lowest set bit).
  function automatic logic moreThanOne(input strobe_vec_t s);
    return (s & (s - NUM_STROBES'(1))) != '0;
  endfunction

endpackage

// File: rtl/count_datapath_tick_prescaler.sv
// Free-running prescaler: counts 0..PRESCALE-1 while enabled, TICK marks the wrap cycle.
module tick_prescaler #(
  parameter int PRESCALE = 50_000_000
) (
  input  logic CLK,
  input  logic RESET,
  input  logic ENABLE,
  output logic TICK
);

  localparam int             CW   = $clog2(PRESCALE);
  localparam logic [CW-1:0]  TERM = CW'(PRESCALE - 1);

  logic [CW-1:0] tickCount_q;
  logic [CW-1:0] tickCount_d;

  assign TICK = ENABLE && (tickCount_q == TERM);

  always_comb begin
    tickCount_d = tickCount_q;
    if (ENABLE) begin
      tickCount_d = TICK ? '0 : tickCount_q + CW'(1);
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      tickCount_q <= '0;
    end else begin
      tickCount_q <= tickCount_d;
    end
  end

endmodule

// File: rtl/count_datapath.sv
// Two-digit BCD count datapath driven one step at a time by an external controller's strobes.
module count_datapath
  import count_datapath_pkg::*;
#(
  parameter int         PRESCALE = 50_000_000,
  parameter logic [7:0] LIMIT    = LIMIT_DEFAULT
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             ENABLE,
  input  logic             S0,
  input  logic             S1,
  input  logic             S2,
  input  logic             S3,
  input  logic             S4,
  input  logic             S5,
  output logic             OVERFLOW,
  output logic             CLR,
  output logic [BCD_W-1:0] COUNT,
  output logic             UPDATE,
  output logic             CARRY,
  output logic             ERR
);

  strobe_vec_t strobes;
  logic        multiStrobe;
  logic        s1Act, s2Act, s3Act, s4Act, s5Act;
  logic        tick;

  logic pending_q, pending_d;
  bcd_t work_q,    work_d;
  logic wrap_q,    wrap_d;
  bcd_t count_q,   count_d;
  logic update_q,  update_d;
  logic carry_q,   carry_d;
  logic err_q,     err_d;

  assign strobes     = {S5, S4, S3, S2, S1, S0};
  assign multiStrobe = moreThanOne(strobes);

  // A collision suppresses every strobe, including S1's pending clear.
  assign s1Act = strobes[S1_IDX] && !multiStrobe;
  assign s2Act = strobes[S2_IDX] && !multiStrobe;
  assign s3Act = strobes[S3_IDX] && !multiStrobe;
  assign s4Act = strobes[S4_IDX] && !multiStrobe;
  assign s5Act = strobes[S5_IDX] && !multiStrobe;

  tick_prescaler #(
    .PRESCALE(PRESCALE)
  ) uPrescaler (
    .CLK   (CLK),
    .RESET (RESET),
    .ENABLE(ENABLE),
    .TICK  (tick)
  );

  always_comb begin
    pending_d = pending_q;
    work_d    = work_q;
    wrap_d    = wrap_q;
    count_d   = count_q;
    update_d  = s5Act;
    carry_d   = s5Act && wrap_q;
    err_d     = err_q || multiStrobe || (tick && pending_q && !s1Act);

    if (s1Act) pending_d = 1'b0;
    if (tick)  pending_d = 1'b1;

    if (s1Act) begin
      work_d = count_q;
    end else if (s3Act) begin
      work_d = work_q + 8'h01;
    end else if (s4Act && (work_q[3:0] > 4'd9)) begin
      work_d = work_q + 8'h06;
    end

    if (s2Act) begin
      wrap_d = (work_q == LIMIT);
    end else if (s5Act) begin
      wrap_d = 1'b0;
    end

    if (s5Act) begin
      count_d = wrap_q ? 8'h00 : work_q;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      pending_q <= 1'b0;
      work_q    <= 8'h00;
      wrap_q    <= 1'b0;
      count_q   <= 8'h00;
      update_q  <= 1'b0;
      carry_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      work_q    <= work_d;
      wrap_q    <= wrap_d;
      count_q   <= count_d;
      update_q  <= update_d;
      carry_q   <= carry_d;
      err_q     <= err_d;
    end
  end

  assign OVERFLOW = pending_q;
  assign CLR      = (work_q == LIMIT);
  assign COUNT    = count_q;
  assign UPDATE   = update_q;
  assign CARRY    = carry_q;
  assign ERR      = err_q;

endmodule

// File: tb/tb_count_datapath.sv
// Directed bench for count_datapath with PRESCALE=4 and LIMIT=8'h59.
module tb_count_datapath;

  localparam logic [5:0] ST_NONE = 6'b000000;
  localparam logic [5:0] ST_S1   = 6'b000010;
  localparam logic [5:0] ST_S2   = 6'b000100;
  localparam logic [5:0] ST_S3   = 6'b001000;
  localparam logic [5:0] ST_S4   = 6'b010000;
  localparam logic [5:0] ST_S5   = 6'b100000;

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       ENABLE = 1'b0;
  logic       S0 = 1'b0, S1 = 1'b0, S2 = 1'b0, S3 = 1'b0, S4 = 1'b0, S5 = 1'b0;
  logic       OVERFLOW, CLR, UPDATE, CARRY, ERR;
  logic [7:0] COUNT;

  int checkCount = 0;
  int failCount  = 0;

  count_datapath #(
    .PRESCALE(4),
    .LIMIT   (8'h59)
  ) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .ENABLE  (ENABLE),
    .S0      (S0),
    .S1      (S1),
    .S2      (S2),
    .S3      (S3),
    .S4      (S4),
    .S5      (S5),
    .OVERFLOW(OVERFLOW),
    .CLR     (CLR),
    .COUNT   (COUNT),
    .UPDATE  (UPDATE),
    .CARRY   (CARRY),
    .ERR     (ERR)
  );

  always #5 CLK = ~CLK;

  task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
    checkCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
    end
  endtask

  task automatic setStrobes(input logic [5:0] v);
    {S5, S4, S3, S2, S1, S0} = v;
  endtask

  // Drive one strobe pattern for exactly one rising edge, then sample 1ns later.
  task automatic applyStimulus(input logic [5:0] v);
    setStrobes(v);
    @(posedge CLK);
    #1;
    setStrobes(ST_NONE);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(ST_NONE);
  endtask

  task automatic stepCount(input int n);
    for (int i = 0; i < n; i++) begin
      applyStimulus(ST_S1);
      applyStimulus(ST_S3);
      applyStimulus(ST_S4);
      applyStimulus(ST_S5);
    end
  endtask

  task automatic doReset(input logic en);
    RESET = 1'b0;
    ENABLE = 1'b0;
    setStrobes(ST_NONE);
    @(posedge CLK);
    #1;
    ENABLE = en;
    RESET = 1'b1;
  endtask

  initial begin
    // Reset state
    #2;
    checkOutput("rst_count", COUNT, 8'h00);
    checkOutput("rst_overflow", {7'b0, OVERFLOW}, 8'h00);
    checkOutput("rst_update", {7'b0, UPDATE}, 8'h00);
    checkOutput("rst_carry", {7'b0, CARRY}, 8'h00);
    checkOutput("rst_err", {7'b0, ERR}, 8'h00);
    checkOutput("rst_clr", {7'b0, CLR}, 8'h00);

    // First tick lands on the 4th enabled edge after release
    doReset(1'b1);
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(ST_NONE);
      checkOutput($sformatf("ovf_pre_%0d", i), {7'b0, OVERFLOW}, 8'h00);
    end
    for (int i = 4; i <= 6; i++) begin
      applyStimulus(ST_NONE);
      checkOutput($sformatf("ovf_hold_%0d", i), {7'b0, OVERFLOW}, 8'h01);
    end

    // 09 -> 10 through a full BCD adjust
    doReset(1'b0);
    stepCount(9);
    checkOutput("count_09", COUNT, 8'h09);
    applyStimulus(ST_S1);
    setStrobes(ST_S2);
    #1;
    checkOutput("clr_in_s2_09", {7'b0, CLR}, 8'h00);
    @(posedge CLK);
    #1;
    setStrobes(ST_NONE);
    applyStimulus(ST_S3);
    applyStimulus(ST_S4);
    applyStimulus(ST_S5);
    checkOutput("count_10", COUNT, 8'h10);
    checkOutput("update_10", {7'b0, UPDATE}, 8'h01);
    checkOutput("carry_10", {7'b0, CARRY}, 8'h00);
    idleCycles(1);
    checkOutput("update_pulse_end", {7'b0, UPDATE}, 8'h00);

    // 59 wraps to 00 with carry
    stepCount(49);
    checkOutput("count_59", COUNT, 8'h59);
    applyStimulus(ST_S1);
    setStrobes(ST_S2);
    #1;
    checkOutput("clr_in_s2_59", {7'b0, CLR}, 8'h01);
    @(posedge CLK);
    #1;
    setStrobes(ST_NONE);
    applyStimulus(ST_S5);
    checkOutput("count_wrap", COUNT, 8'h00);
    checkOutput("update_wrap", {7'b0, UPDATE}, 8'h01);
    checkOutput("carry_wrap", {7'b0, CARRY}, 8'h01);
    checkOutput("err_clean", {7'b0, ERR}, 8'h00);
    idleCycles(1);
    checkOutput("carry_pulse_end", {7'b0, CARRY}, 8'h00);

    // Tick coincident with S1 keeps pending; a later unserviced tick is an error
    doReset(1'b1);
    idleCycles(7);
    applyStimulus(ST_S1);
    checkOutput("ovf_tick_s1", {7'b0, OVERFLOW}, 8'h01);
    checkOutput("err_tick_s1", {7'b0, ERR}, 8'h00);
    applyStimulus(ST_S1);
    checkOutput("ovf_cleared", {7'b0, OVERFLOW}, 8'h00);
    idleCycles(3);
    checkOutput("ovf_third_tick", {7'b0, OVERFLOW}, 8'h01);
    checkOutput("err_before_lost", {7'b0, ERR}, 8'h00);
    idleCycles(4);
    checkOutput("err_tick_lost", {7'b0, ERR}, 8'h01);
    ENABLE = 1'b0;
    idleCycles(5);
    checkOutput("err_sticky", {7'b0, ERR}, 8'h01);

    // Strobe collision leaves WORK alone
    doReset(1'b0);
    stepCount(3);
    applyStimulus(ST_S1);
    applyStimulus(ST_S3 | ST_S4);
    checkOutput("err_collision", {7'b0, ERR}, 8'h01);
    applyStimulus(ST_S5);
    checkOutput("count_after_collision", COUNT, 8'h03);

    // Reset mid-sequence aborts without a commit
    doReset(1'b0);
    stepCount(42);
    checkOutput("count_42", COUNT, 8'h42);
    applyStimulus(ST_S1);
    applyStimulus(ST_S2);
    setStrobes(ST_S3);
    #2;
    RESET = 1'b0;
    #1;
    checkOutput("abort_count", COUNT, 8'h00);
    checkOutput("abort_update", {7'b0, UPDATE}, 8'h00);
    checkOutput("abort_carry", {7'b0, CARRY}, 8'h00);
    checkOutput("abort_err", {7'b0, ERR}, 8'h00);
    checkOutput("abort_overflow", {7'b0, OVERFLOW}, 8'h00);
    checkOutput("abort_clr", {7'b0, CLR}, 8'h00);
    setStrobes(ST_NONE);
    @(posedge CLK);
    #1;
    RESET = 1'b1;
    idleCycles(2);
    checkOutput("abort_no_update", {7'b0, UPDATE}, 8'h00);
    checkOutput("abort_count_held", COUNT, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
